// File: rtl/piano_pkg.sv
// Shared types and constants for the piano song path.
// Score word = {dur[3:0], note[5:0]}; FSM state encoding.
package piano_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_ADV,
    S_DONE
  } state_t;

  localparam int DUR_W        = 4;
  localparam int NOTE_W       = 6;
  localparam int WORD_W       = DUR_W + NOTE_W;
  localparam int TICK_DIV_DEF = 3_000_000;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 6'h3F;

  function automatic logic is_end(
    input logic [WORD_W-1:0] w
  );
    return (w[NOTE_W-1:0] == NOTE_END) ||
           (w[WORD_W-1:NOTE_W] == '0);
  endfunction

endpackage

// File: rtl/score_rom.sv
// Registered-output score ROM, SONG_LEN words of {dur, note}.
// Ports: clk, i_addr (word address), o_data (word, 1 clk after i_addr).
module score_rom
  import piano_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int SONG_LEN = 64,
  parameter logic [SONG_LEN*WORD_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] o_data
);

  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] r_data;

  // Out-of-range addresses read back as an end marker.
  always_comb begin
    w_word = {{DUR_W{1'b0}}, NOTE_END};
    for (int i = 0; i < SONG_LEN; i++) begin
      if (i_addr == ADDR_W'(i))
        w_word = INIT[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    r_data <= w_word;
  end

  assign o_data = r_data;

endmodule

// File: rtl/song_sequencer.sv
// Autoplay front-end: steps a score ROM and drives the voice stage.
// Ports: clk, rst_n, play_btn, stop_btn, rom_addr, rom_data, stat, note, song_done.
module song_sequencer
  import piano_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int ADDR_W    = 6,
  parameter int SONG_LEN  = 64,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play_btn,
  input  logic              stop_btn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              stat,
  output logic [NOTE_W-1:0] note,
  output logic              song_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] G_LAST =
    GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(SONG_LEN - 1);

  state_t r_state;
  state_t w_next;

  logic              r_play_prev;
  logic              r_stop_prev;
  logic [PW-1:0]     r_presc;
  logic [DUR_W-1:0]  r_dur;
  logic [GW-1:0]     r_gap;
  logic [ADDR_W-1:0] r_addr;
  logic [NOTE_W-1:0] r_note;
  logic              r_stat;
  logic              r_done;

  logic w_play_edge;
  logic w_stop_edge;
  logic w_abort;
  logic w_wrap;
  logic w_end;
  logic w_last_tick;

  assign w_play_edge = play_btn & ~r_play_prev;
  assign w_stop_edge = stop_btn & ~r_stop_prev;
  assign w_abort     = w_stop_edge && (r_state != S_IDLE);
  assign w_wrap      = (r_presc == P_LAST);
  assign w_end       = is_end(rom_data);
  assign w_last_tick = w_wrap && (r_dur == 4'd1);

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          // stop wins over a coincident play
          if (w_play_edge && !w_stop_edge)
            w_next = S_FETCH;
        S_FETCH: w_next = S_LOAD;
        S_LOAD:  w_next = w_end ? S_DONE : S_PLAY;
        S_PLAY:
          if (w_last_tick)
            w_next = (GAP_TICKS > 0) ? S_GAP : S_ADV;
        S_GAP:
          if (w_wrap && (r_gap == G_LAST))
            w_next = S_ADV;
        S_ADV:
          w_next = (r_addr == A_LAST) ? S_DONE : S_FETCH;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_play_prev <= 1'b0;
      r_stop_prev <= 1'b0;
      r_presc     <= '0;
      r_dur       <= '0;
      r_gap       <= '0;
      r_addr      <= '0;
      r_note      <= NOTE_REST;
      r_stat      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_play_prev <= play_btn;
      r_stop_prev <= stop_btn;
      r_stat      <= (w_next != S_IDLE) &&
                     (w_next != S_DONE);
      r_done      <= (w_next == S_DONE);

      // Prescaler free-runs through PLAY and GAP.
      if (r_state == S_LOAD)
        r_presc <= '0;
      else if (r_state == S_PLAY || r_state == S_GAP)
        r_presc <= w_wrap ? '0 : r_presc + 1'b1;

      if (r_state == S_LOAD)
        r_dur <= rom_data[WORD_W-1:NOTE_W];
      else if (r_state == S_PLAY && w_wrap)
        r_dur <= r_dur - 1'b1;

      if (r_state == S_PLAY)
        r_gap <= '0;
      else if (r_state == S_GAP && w_wrap)
        r_gap <= r_gap + 1'b1;

      if (w_next == S_IDLE)
        r_addr <= '0;
      else if (r_state == S_ADV && w_next == S_FETCH)
        r_addr <= r_addr + 1'b1;

      if (w_next == S_IDLE)
        r_note <= NOTE_REST;
      else if (r_state == S_LOAD && !w_end)
        r_note <= rom_data[NOTE_W-1:0];
      else if (r_state == S_PLAY && w_last_tick)
        r_note <= NOTE_REST;
    end
  end

  assign rom_addr  = r_addr;
  assign stat      = r_stat;
  assign note      = r_note;
  assign song_done = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: score table, hand corner cases,
// random scores against a trace model built from the score rules.
module tb_song_sequencer;

  localparam int TD     = 4;
  localparam int GAP    = 1;
  localparam int LEN    = 4;
  localparam int NOSTOP = 1_000_000;

  typedef struct packed {
    logic       stat;
    logic [5:0] note;
    logic [5:0] addr;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [3:0][9:0] w;
    logic            hw;
    int              done_idx;
    int              max_addr;
    int              nz_cycles;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       play_btn;
  logic       stop_btn;
  logic [5:0] rom_addr;
  logic [9:0] rom_data;
  logic       stat;
  logic [5:0] note;
  logic       song_done;

  logic [9:0] rom [LEN];
  logic [9:0] tb_rdata;
  logic [9:0] hw_rdata;
  logic       use_hw;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   m_done;
  int   m_maxa;
  int   m_nz;
  vec_t vt [5];

  always #5 clk = ~clk;

  song_sequencer #(
    .TICK_DIV (TD),
    .ADDR_W   (6),
    .SONG_LEN (LEN),
    .GAP_TICKS(GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .play_btn (play_btn),
    .stop_btn (stop_btn),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .stat     (stat),
    .note     (note),
    .song_done(song_done)
  );

  score_rom #(
    .ADDR_W  (6),
    .SONG_LEN(LEN),
    .INIT    ({10'h03F, 10'h040, 10'h08D, 10'h101})
  ) u_rom (
    .clk   (clk),
    .i_addr(rom_addr),
    .o_data(hw_rdata)
  );

  always_ff @(posedge clk)
    tb_rdata <= (rom_addr < 6'(LEN)) ? rom[rom_addr[1:0]] : 10'h3FF;

  assign rom_data = use_hw ? hw_rdata : tb_rdata;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [5:0] n,
                              input int a, input logic d);
    exp_t e;
    e.stat = s;
    e.note = n;
    e.addr = 6'(a);
    e.done = d;
    return e;
  endfunction

  // Expected per-clock outputs, index 0 = clock that sees the play edge.
  function automatic void build_model();
    logic [3:0] d;
    logic [5:0] n;
    exp_q.delete();
    for (int a = 0; a < LEN; a++) begin
      d = rom[a][9:6];
      n = rom[a][5:0];
      exp_q.push_back(mk(1'b1, 6'd0, a, 1'b0));
      exp_q.push_back(mk(1'b1, 6'd0, a, 1'b0));
      if (n == 6'h3F || d == 4'd0) begin
        exp_q.push_back(mk(1'b0, 6'd0, a, 1'b1));
        return;
      end
      repeat (int'(d) * TD) exp_q.push_back(mk(1'b1, n, a, 1'b0));
      repeat (GAP * TD) exp_q.push_back(mk(1'b1, 6'd0, a, 1'b0));
      exp_q.push_back(mk(1'b1, 6'd0, a, 1'b0));
    end
    exp_q.push_back(mk(1'b0, 6'd0, LEN - 1, 1'b1));
  endfunction

  task automatic run(input string tag, input int stop_at,
                     input bit hold, input bit both);
    int   n;
    exp_t e;
    exp_t act;
    n = exp_q.size() + 4;
    m_done = -1;
    m_maxa = 0;
    m_nz   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      play_btn = (i == 0) || hold || (both && i == stop_at);
      stop_btn = (i == stop_at);
      @(posedge clk);
      #1;
      if (i < stop_at && i < exp_q.size())
        e = exp_q[i];
      else
        e = mk(1'b0, 6'd0, 0, 1'b0);
      act = mk(stat, note, int'(rom_addr), song_done);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s cyc%0d got s%0b n%0d a%0d d%0b want s%0b n%0d a%0d d%0b",
                 tag, i, act.stat, act.note, act.addr, act.done,
                 e.stat, e.note, e.addr, e.done);
      end
      if (song_done === 1'b1 && m_done < 0) m_done = i;
      if (int'(rom_addr) > m_maxa) m_maxa = int'(rom_addr);
      if (note !== 6'd0) m_nz++;
    end
    @(negedge clk);
    play_btn = hold;
    stop_btn = 1'b0;
  endtask

  task automatic load_test1();
    rom[0] = 10'h101;
    rom[1] = 10'h08D;
    rom[2] = 10'h040;
    rom[3] = 10'h03F;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    use_hw   = 1'b0;
    rst_n    = 1'b0;
    play_btn = 1'b0;
    stop_btn = 1'b0;
    load_test1();

    vt[0] = '{w: {10'h03F, 10'h040, 10'h08D, 10'h101}, hw: 1'b1,
              done_idx: 51, max_addr: 3, nz_cycles: 24};
    vt[1] = '{w: {10'h048, 10'h047, 10'h046, 10'h045}, hw: 1'b0,
              done_idx: 44, max_addr: 3, nz_cycles: 16};
    vt[2] = '{w: {10'h041, 10'h041, 10'h041, 10'h0FF}, hw: 1'b0,
              done_idx: 2, max_addr: 0, nz_cycles: 0};
    vt[3] = '{w: {10'h041, 10'h041, 10'h005, 10'h094}, hw: 1'b0,
              done_idx: 17, max_addr: 1, nz_cycles: 8};
    vt[4] = '{w: {10'h041, 10'h041, 10'h000, 10'h3F0}, hw: 1'b0,
              done_idx: 69, max_addr: 1, nz_cycles: 60};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stat", 32'(stat), 0);
    chk("rst_note", 32'(note), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_done", 32'(song_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int a = 0; a < LEN; a++) rom[a] = vt[v].w[a];
      use_hw = vt[v].hw;
      build_model();
      run($sformatf("vec%0d", v), NOSTOP, 1'b0, 1'b0);
      chk($sformatf("vec%0d_done_idx", v), 32'(m_done), 32'(vt[v].done_idx));
      chk($sformatf("vec%0d_max_addr", v), 32'(m_maxa), 32'(vt[v].max_addr));
      chk($sformatf("vec%0d_nz", v), 32'(m_nz), 32'(vt[v].nz_cycles));
    end
    use_hw = 1'b0;

    load_test1();
    build_model();
    run("stop2nd", 30, 1'b0, 1'b0);
    chk("stop2nd_no_done", 32'(m_done), 32'hFFFF_FFFF);
    run("restart", NOSTOP, 1'b0, 1'b0);

    run("both_busy", 20, 1'b0, 1'b1);
    chk("both_busy_no_done", 32'(m_done), 32'hFFFF_FFFF);

    @(negedge clk);
    play_btn = 1'b1;
    stop_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("both_idle_stat%0d", i), 32'(stat), 0);
      chk($sformatf("both_idle_addr%0d", i), 32'(rom_addr), 0);
    end
    @(negedge clk);
    play_btn = 1'b0;
    stop_btn = 1'b0;
    run("after_both", NOSTOP, 1'b0, 1'b0);

    @(negedge clk);
    play_btn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    play_btn = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("arst_pre_note", 32'(note), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_stat", 32'(stat), 0);
    chk("arst_note", 32'(note), 0);
    chk("arst_addr", 32'(rom_addr), 0);
    chk("arst_done", 32'(song_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("arst_idle%0d", i), 32'(stat), 0);
    end
    run("arst_restart", NOSTOP, 1'b0, 1'b0);

    run("held", NOSTOP, 1'b1, 1'b0);
    chk("held_done", 32'(m_done), 32'd51);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held_idle%0d", i), 32'(stat), 0);
    end
    @(negedge clk);
    play_btn = 1'b0;
    run("held_rerun", NOSTOP, 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int r;
      int s;
      for (int a = 0; a < LEN; a++) begin
        r = $urandom_range(0, 15);
        if (r == 0)
          rom[a] = {4'd0, 6'($urandom_range(1, 48))};
        else if (r == 1)
          rom[a] = {4'($urandom_range(1, 3)), 6'h3F};
        else
          rom[a] = {4'($urandom_range(1, 4)), 6'($urandom_range(0, 48))};
      end
      build_model();
      s = ($urandom_range(0, 1) == 1) ?
          $urandom_range(1, exp_q.size()) : NOSTOP;
      run($sformatf("rnd%0d", t), s, 1'b0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
